chip_test_sequencer: RTL and testbench

Top-level controller for the chip checker. It selects one of NUM_CHIPS per-chip tester modules (7400/7404/… testers) from the user's chip-select switches and launches that tester with a single-cycle Run pulse. It then waits for the tester's Done with a timeout, captures its RSLT, sends the DISP_RSLT release back to the tester, and holds a Pass/Fail/Timeout indication for the LEDs until the user acknowledges.

---
 rtl/chip_test_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_chip_test_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/chip_test_sequencer.sv
// chip_test_sequencer: top-level controller for the chip checker.
// A rising edge on Start selects one of NUM_CHIPS tester slots (ChipSel)
// and sends it a one-cycle Run pulse. The controller then waits a bounded
// time for that slot's Done, captures its RSLT, and sends it a one-cycle
// DISP_RSLT release. The outcome is held for the LEDs until Ack rises.
//   Clk, Reset          : clock, synchronous active-high reset
//   Start, Ack          : user buttons (level, already synchronised)
//   ChipSel             : index of the tester slot to run
//   Run_out, DISP_RSLT  : one-hot single-cycle strobes to the selected slot
//   Done_in, RSLT_in    : per-slot done and pass(1)/fail(0) from the testers
//   Busy, Result_valid  : test in progress / outcome on display
//   Pass, Fail, Timeout, Bad_sel, Cycles : outcome of the last test
module chip_test_sequencer #(
   parameter int unsigned NUM_CHIPS      = 8,
   parameter int unsigned SEL_W          = 3,
   parameter int unsigned TO_W           = 10,
   parameter int unsigned TIMEOUT_CYCLES = 1000
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 Start,
   input  logic                 Ack,
   input  logic [SEL_W-1:0]     ChipSel,
   output logic [NUM_CHIPS-1:0] Run_out,
   input  logic [NUM_CHIPS-1:0] Done_in,
   input  logic [NUM_CHIPS-1:0] RSLT_in,
   output logic [NUM_CHIPS-1:0] DISP_RSLT,
   output logic                 Busy,
   output logic                 Result_valid,
   output logic                 Pass,
   output logic                 Fail,
   output logic                 Timeout,
   output logic                 Bad_sel,
   output logic [TO_W-1:0]      Cycles
);

   typedef enum logic [2:0] {
      S_IDLE, S_LAUNCH, S_WAIT, S_CAPTURE, S_SHOW
   } state_e;

   localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TO_W-1:0] CNT_MAX  = '1;

   state_e               state_q, state_d;
   logic [SEL_W-1:0]     sel_q, sel_d;
   logic [TO_W-1:0]      cnt_q, cnt_d;
   logic                 start_prev_q, start_prev_d;
   logic                 ack_prev_q, ack_prev_d;
   logic [NUM_CHIPS-1:0] run_q, run_d;
   logic [NUM_CHIPS-1:0] disp_q, disp_d;
   logic                 busy_q, busy_d;
   logic                 valid_q, valid_d;
   logic                 pass_q, pass_d;
   logic                 fail_q, fail_d;
   logic                 timeout_q, timeout_d;
   logic                 bad_q, bad_d;
   logic [TO_W-1:0]      cycles_q, cycles_d;

   logic                 start_rise_c, ack_rise_c;
   logic [NUM_CHIPS-1:0] sel_oh_c;
   logic                 done_sel_c, rslt_sel_c;

   // Edge detection and selected-slot views (non-selected slots masked off)
   always_comb begin
      start_rise_c = Start & ~start_prev_q;
      ack_rise_c   = Ack & ~ack_prev_q;
      sel_oh_c     = NUM_CHIPS'(1) << sel_q;
      done_sel_c   = |(Done_in & sel_oh_c);
      rslt_sel_c   = |(RSLT_in & sel_oh_c);
   end

   // Next-state and registered-output logic; outputs track the next state
   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      cnt_d        = cnt_q;
      start_prev_d = Start;
      ack_prev_d   = Ack;
      run_d        = '0;
      disp_d       = '0;
      pass_d       = pass_q;
      fail_d       = fail_q;
      timeout_d    = timeout_q;
      bad_d        = bad_q;
      cycles_d     = cycles_q;

      case (state_q)
         S_IDLE: begin
            if (start_rise_c) begin
               sel_d     = ChipSel;
               pass_d    = 1'b0;
               fail_d    = 1'b0;
               timeout_d = 1'b0;
               bad_d     = 1'b0;
               cycles_d  = '0;
               if (32'(ChipSel) >= NUM_CHIPS) begin
                  bad_d   = 1'b1;
                  fail_d  = 1'b1;
                  state_d = S_SHOW;
               end else begin
                  run_d   = NUM_CHIPS'(1) << ChipSel;
                  state_d = S_LAUNCH;
               end
            end
         end
         S_LAUNCH: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // Done takes priority over a timeout in the same cycle
            if (done_sel_c) begin
               cycles_d = cnt_q;
               disp_d   = sel_oh_c;
               state_d  = S_CAPTURE;
            end else if (cnt_q == CNT_LAST) begin
               cycles_d  = cnt_q;
               timeout_d = 1'b1;
               fail_d    = 1'b1;
               state_d   = S_SHOW;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + TO_W'(1);
            end
         end
         S_CAPTURE: begin
            // RSLT is sampled a cycle after Done so the tester's flop has settled
            pass_d  = rslt_sel_c;
            fail_d  = ~rslt_sel_c;
            state_d = S_SHOW;
         end
         S_SHOW: begin
            if (ack_rise_c) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d  = (state_d == S_LAUNCH) || (state_d == S_WAIT) || (state_d == S_CAPTURE);
      valid_d = (state_d == S_SHOW);
   end

   // State and output registers; button history starts high so a held button must be released
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q      <= S_IDLE;
         sel_q        <= '0;
         cnt_q        <= '0;
         start_prev_q <= 1'b1;
         ack_prev_q   <= 1'b1;
         run_q        <= '0;
         disp_q       <= '0;
         busy_q       <= 1'b0;
         valid_q      <= 1'b0;
         pass_q       <= 1'b0;
         fail_q       <= 1'b0;
         timeout_q    <= 1'b0;
         bad_q        <= 1'b0;
         cycles_q     <= '0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         cnt_q        <= cnt_d;
         start_prev_q <= start_prev_d;
         ack_prev_q   <= ack_prev_d;
         run_q        <= run_d;
         disp_q       <= disp_d;
         busy_q       <= busy_d;
         valid_q      <= valid_d;
         pass_q       <= pass_d;
         fail_q       <= fail_d;
         timeout_q    <= timeout_d;
         bad_q        <= bad_d;
         cycles_q     <= cycles_d;
      end
   end

   assign Run_out      = run_q;
   assign DISP_RSLT    = disp_q;
   assign Busy         = busy_q;
   assign Result_valid = valid_q;
   assign Pass         = pass_q;
   assign Fail         = fail_q;
   assign Timeout      = timeout_q;
   assign Bad_sel      = bad_q;
   assign Cycles       = cycles_q;

endmodule

// File: tb/tb_chip_test_sequencer.sv
// Self-checking bench for chip_test_sequencer, built with six tester slots
// so that ChipSel values 6 and 7 are out of range.
module tb_chip_test_sequencer;

   localparam int NC    = 6;
   localparam int SW    = 3;
   localparam int TW    = 10;
   localparam int TMO   = 1000;
   localparam int NEVER = 5000;

   logic          Clk = 1'b0;
   logic          Reset = 1'b1;
   logic          Start = 1'b0;
   logic          Ack = 1'b0;
   logic [SW-1:0] ChipSel = '0;
   logic [NC-1:0] Done_in = '0;
   logic [NC-1:0] RSLT_in = '0;
   logic [NC-1:0] Run_out, DISP_RSLT;
   logic          Busy, Result_valid, Pass, Fail, Timeout, Bad_sel;
   logic [TW-1:0] Cycles;

   int n_cmp = 0;
   int n_err = 0;

   chip_test_sequencer #(
      .NUM_CHIPS(NC), .SEL_W(SW), .TO_W(TW), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack), .ChipSel(ChipSel),
      .Run_out(Run_out), .Done_in(Done_in), .RSLT_in(RSLT_in),
      .DISP_RSLT(DISP_RSLT), .Busy(Busy), .Result_valid(Result_valid),
      .Pass(Pass), .Fail(Fail), .Timeout(Timeout), .Bad_sel(Bad_sel),
      .Cycles(Cycles)
   );

   always #5 Clk = ~Clk;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, got running want finished");
      $fatal(1);
   end

   typedef struct {
      int sel;
      int delay;
      bit rslt;
      bit e_pass;
      bit e_fail;
      bit e_to;
      bit e_bad;
      int e_cyc;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(int sel, int delay, bit rslt, bit p, bit f, bit t, bit b, int c);
      vec_t v;
      v.sel = sel; v.delay = delay; v.rslt = rslt;
      v.e_pass = p; v.e_fail = f; v.e_to = t; v.e_bad = b; v.e_cyc = c;
      return v;
   endfunction

   // Reference outcome: bad index fails at once, Done within the window
   // reports its delay and RSLT, otherwise a timeout at the last window cycle.
   function automatic vec_t model(int sel, int delay, bit rslt);
      vec_t v;
      v = mk(sel, delay, rslt, 0, 0, 0, 0, 0);
      if (sel >= NC) begin
         v.e_bad = 1; v.e_fail = 1;
      end else if (delay < TMO) begin
         v.e_pass = rslt; v.e_fail = !rslt; v.e_cyc = delay;
      end else begin
         v.e_to = 1; v.e_fail = 1; v.e_cyc = TMO - 1;
      end
      return v;
   endfunction

   task automatic check_outcome(input string tag, input vec_t v);
      chk({tag, "_pass"},    32'(Pass),    32'(v.e_pass));
      chk({tag, "_fail"},    32'(Fail),    32'(v.e_fail));
      chk({tag, "_timeout"}, 32'(Timeout), 32'(v.e_to));
      chk({tag, "_bad_sel"}, 32'(Bad_sel), 32'(v.e_bad));
      chk({tag, "_cycles"},  32'(Cycles),  32'(v.e_cyc));
   endtask

   // One full test: Start pulse, tester model answering, SHOW, Ack.
   task automatic run_test(input vec_t v, input bit poke_in);
      logic [NC-1:0] oh;
      logic [NC-1:0] noise;
      bit done;
      bit poke;
      poke = poke_in && (v.delay >= 5);
      oh = (v.sel < NC) ? (NC'(1) << v.sel) : '0;
      @(negedge Clk);
      ChipSel = SW'(v.sel);
      Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      ChipSel = SW'($urandom);
      if (v.sel >= NC) begin
         chk("bad_no_run", 32'(Run_out), 32'(0));
         chk("bad_busy", 32'(Busy), 32'(0));
      end else begin
         chk("run_pulse", 32'(Run_out), 32'(oh));
         chk("launch_busy", 32'(Busy), 32'(1));
         chk("launch_valid", 32'(Result_valid), 32'(0));
         done = 1'b0;
         for (int k = 0; k < TMO && !done; k++) begin
            @(negedge Clk);
            chk("wait_state", 32'({Busy, DISP_RSLT, Run_out}), 32'({1'b1, NC'(0), NC'(0)}));
            noise = NC'($urandom) & ~oh;
            if (v.sel == 1) noise[2] = 1'b1;
            Done_in = noise | ((k == v.delay) ? oh : NC'(0));
            RSLT_in = NC'($urandom);
            // Tester RSLT not yet settled on the Done cycle
            if (k == v.delay) RSLT_in = v.rslt ? (RSLT_in & ~oh) : (RSLT_in | oh);
            if (poke && k == 2) Start = 1'b1;
            if (poke && k == 3) begin Start = 1'b0; Ack = 1'b1; end
            if (poke && k == 4) Ack = 1'b0;
            if (k == v.delay) done = 1'b1;
         end
         if (done) begin
            @(negedge Clk);
            chk("disp_pulse", 32'(DISP_RSLT), 32'(oh));
            chk("capture_busy", 32'(Busy), 32'(1));
            chk("capture_no_run", 32'(Run_out), 32'(0));
            Done_in = NC'($urandom) & ~oh;
            RSLT_in = NC'($urandom);
            RSLT_in = v.rslt ? (RSLT_in | oh) : (RSLT_in & ~oh);
         end
         @(negedge Clk);
         Done_in = '0;
         chk("show_no_disp", 32'(DISP_RSLT), 32'(0));
      end
      chk("show_valid", 32'(Result_valid), 32'(1));
      chk("show_busy", 32'(Busy), 32'(0));
      check_outcome("show", v);
      Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      chk("show_ignores_start", 32'({Result_valid, Busy, Run_out}), 32'({1'b1, 1'b0, NC'(0)}));
      @(negedge Clk);
      Ack = 1'b1;
      @(negedge Clk);
      Ack = 1'b0;
      chk("ack_idle", 32'({Result_valid, Busy, Run_out, DISP_RSLT}), 32'(0));
      check_outcome("held", v);
   endtask

   vec_t tab[9];

   initial begin
      vec_t v;
      int sel, dly, pick;
      bit r;

      tab[0] = mk(1, 6,     1, 1, 0, 0, 0, 6);
      tab[1] = mk(1, 6,     0, 0, 1, 0, 0, 6);
      tab[2] = mk(3, NEVER, 1, 0, 1, 1, 0, 999);
      tab[3] = mk(3, 999,   1, 1, 0, 0, 0, 999);
      tab[4] = mk(7, 0,     1, 0, 1, 0, 1, 0);
      tab[5] = mk(6, 0,     1, 0, 1, 0, 1, 0);
      tab[6] = mk(0, 0,     1, 1, 0, 0, 0, 0);
      tab[7] = mk(5, 998,   0, 0, 1, 0, 0, 998);
      tab[8] = mk(2, 13,    0, 0, 1, 0, 0, 13);

      // Reset with Start held high
      Reset = 1'b1;
      Start = 1'b1;
      repeat (3) @(negedge Clk);
      chk("reset_outputs",
          32'({Run_out, DISP_RSLT, Busy, Result_valid, Pass, Fail, Timeout, Bad_sel, Cycles}),
          32'(0));
      Reset = 1'b0;
      repeat (4) begin
         @(negedge Clk);
         chk("held_start_no_launch", 32'({Busy, Run_out, Result_valid}), 32'(0));
      end
      Start = 1'b0;
      @(negedge Clk);

      for (int i = 0; i < 9; i++) run_test(tab[i], (i % 2) == 1);

      // Reset in the middle of WAIT
      @(negedge Clk);
      ChipSel = SW'(2);
      Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      repeat (5) @(negedge Clk);
      chk("mid_wait_busy", 32'(Busy), 32'(1));
      Reset = 1'b1;
      @(negedge Clk);
      chk("reset_mid_wait",
          32'({Run_out, DISP_RSLT, Busy, Result_valid, Pass, Fail, Timeout, Bad_sel, Cycles}),
          32'(0));
      Reset = 1'b0;
      repeat (2) @(negedge Clk);
      chk("after_reset_idle", 32'({Busy, Result_valid, Run_out}), 32'(0));
      run_test(model(4, 9, 1), 1'b0);

      // Randomized tests against the reference outcome
      for (int i = 0; i < 30; i++) begin
         sel  = int'($urandom_range(0, 7));
         r    = 1'($urandom_range(0, 1));
         pick = int'($urandom_range(0, 19));
         if (pick == 0)      dly = NEVER;
         else if (pick == 1) dly = TMO - 1;
         else                dly = int'($urandom_range(0, 40));
         v = model(sel, dly, r);
         run_test(v, 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
